bc_bist: RTL and testbench



---
 rtl/bc_bist.sv | 199 +++++++++++++++++++
 tb/tb_bc_bist.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bc_bist.sv
// Exhaustive self-tester for the 2-bit comparator: sweeps all 16 operand vectors and checks {LB,E,RB}.
// Optional macro BC_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
`timescale 1ns/1ps
module bc_bist #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a1,
  output logic       a2,
  output logic       b1,
  output logic       b2,
  input  logic       LB,
  input  logic       E,
  input  logic       RB,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic [3:0] fail_idx,
  output logic       fail_valid
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // A zero settle window is promoted to one cycle; the wait counter is 4 bits wide.
  localparam int         SETTLE_EFF  = (SETTLE < 1) ? 1 : ((SETTLE > 15) ? 15 : SETTLE);
  localparam logic [3:0] WAIT_RELOAD = 4'(SETTLE_EFF - 1);
  localparam logic [4:0] ERR_MAX     = 5'd16;

  // Golden comparator: A={a1,a2}={v[0],v[1]}, B={b1,b2}={v[2],v[3]}, one-hot {LB,E,RB}.
  function automatic logic [2:0] golden_resp(input logic [3:0] v);
    logic [1:0] op_a;
    logic [1:0] op_b;
    op_a = {v[0], v[1]};
    op_b = {v[2], v[3]};
    if (op_a > op_b) begin
      golden_resp = 3'b100;
    end else if (op_a == op_b) begin
      golden_resp = 3'b010;
    end else begin
      golden_resp = 3'b001;
    end
  endfunction

  state_t     state_r,      state_s;
  logic [3:0] idx_r,        idx_s;
  logic [3:0] wait_r,       wait_s;
  logic [3:0] operand_r,    operand_s;
  logic       busy_r,       busy_s;
  logic       done_r,       done_s;
  logic       pass_r,       pass_s;
  logic [4:0] err_cnt_r,    err_cnt_s;
  logic [3:0] fail_idx_r,   fail_idx_s;
  logic       fail_valid_r, fail_valid_s;
  logic       mismatch_s;
  logic       finish_s;
  logic [4:0] err_next_s;

  assign mismatch_s = ({LB, E, RB} != golden_resp(idx_r));

  // Next-state and next-output logic for the sweep controller.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    wait_s       = wait_r;
    operand_s    = operand_r;
    busy_s       = busy_r;
    done_s       = done_r;
    pass_s       = pass_r;
    err_cnt_s    = err_cnt_r;
    fail_idx_s   = fail_idx_r;
    fail_valid_s = fail_valid_r;
    finish_s     = 1'b0;
    err_next_s   = err_cnt_r;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s      = ST_SETTLE;
          idx_s        = 4'd0;
          wait_s       = WAIT_RELOAD;
          operand_s    = 4'd0;
          busy_s       = 1'b1;
          done_s       = 1'b0;
          pass_s       = 1'b0;
          err_cnt_s    = 5'd0;
          fail_idx_s   = 4'd0;
          fail_valid_s = 1'b0;
        end else begin
          state_s = state_r;
        end
      end

      ST_SETTLE: begin
        if (wait_r == 4'd0) begin
          state_s = ST_CHECK;
        end else begin
          wait_s = wait_r - 4'd1;
        end
      end

      ST_CHECK: begin
        // Sixteen vectors bound the count at 16; the guard keeps it from wrapping regardless.
        if (mismatch_s && (err_cnt_r != ERR_MAX)) begin
          err_next_s = err_cnt_r + 5'd1;
        end else begin
          err_next_s = err_cnt_r;
        end
        err_cnt_s = err_next_s;

        if (mismatch_s && !fail_valid_r) begin
          fail_idx_s   = idx_r;
          fail_valid_s = 1'b1;
        end else begin
          fail_idx_s   = fail_idx_r;
          fail_valid_s = fail_valid_r;
        end

`ifdef BC_BIST_STOP_ON_FAIL_EN
        finish_s = mismatch_s || (idx_r == 4'd15);
`else
        finish_s = (idx_r == 4'd15);
`endif

        if (finish_s) begin
          state_s   = ST_DONE;
          operand_s = 4'd0;
          busy_s    = 1'b0;
          done_s    = 1'b1;
          pass_s    = (err_next_s == 5'd0);
        end else begin
          state_s   = ST_SETTLE;
          idx_s     = idx_r + 4'd1;
          operand_s = idx_r + 4'd1;
          wait_s    = WAIT_RELOAD;
        end
      end

      default: begin
        state_s      = ST_IDLE;
        idx_s        = 4'd0;
        wait_s       = 4'd0;
        operand_s    = 4'd0;
        busy_s       = 1'b0;
        done_s       = 1'b0;
        pass_s       = 1'b0;
        err_cnt_s    = 5'd0;
        fail_idx_s   = 4'd0;
        fail_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      idx_r        <= 4'd0;
      wait_r       <= 4'd0;
      operand_r    <= 4'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      err_cnt_r    <= 5'd0;
      fail_idx_r   <= 4'd0;
      fail_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      wait_r       <= wait_s;
      operand_r    <= operand_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      pass_r       <= pass_s;
      err_cnt_r    <= err_cnt_s;
      fail_idx_r   <= fail_idx_s;
      fail_valid_r <= fail_valid_s;
    end
  end

  assign a1         = operand_r[0];
  assign a2         = operand_r[1];
  assign b1         = operand_r[2];
  assign b2         = operand_r[3];
  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign err_cnt    = err_cnt_r;
  assign fail_idx   = fail_idx_r;
  assign fail_valid = fail_valid_r;

endmodule

// File: tb/tb_bc_bist.sv
// Scoreboard bench for bc_bist: a behavioural comparator stub with injectable faults feeds the tester.
`timescale 1ns/1ps
module tb_bc_bist;

`ifdef BC_BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       a1, a2, b1, b2;
  logic       LB, E, RB;
  logic       busy, done, pass, fail_valid;
  logic [4:0] err_cnt;
  logic [3:0] fail_idx;
  int         mode = 0;   // 0 good, 1 E stuck 0, 2 LB/RB swapped, 3 all-zero response

  bc_bist #(.SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a1(a1), .a2(a2), .b1(b1), .b2(b2),
    .LB(LB), .E(E), .RB(RB),
    .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_idx(fail_idx), .fail_valid(fail_valid)
  );

  always #5 clk = ~clk;

  // Comparator under test, with selectable faults.
  always_comb begin
    logic [1:0] va, vb;
    logic gt, eq, lt;
    va = {a1, a2};
    vb = {b1, b2};
    gt = (va > vb);
    eq = (va == vb);
    lt = (va < vb);
    LB = gt; E = eq; RB = lt;
    case (mode)
      1: E = 1'b0;
      2: begin LB = lt; RB = gt; end
      3: begin LB = 1'b0; E = 1'b0; RB = 1'b0; end
      default: ;
    endcase
  end

  typedef struct {
    int lat;
    int err;
    int fidx;
    int fvalid;
    int pss;
    int start_edge;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_start = 0;
  bit   done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic pulse_start(input bit accept, input int lat, input int err,
                             input int fidx, input int fv, input int ps);
    exp_t x;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (accept) begin
      last_start = cyc;
      x.lat = lat; x.err = err; x.fidx = fidx; x.fvalid = fv; x.pss = ps;
      x.start_edge = cyc;
      sb_q.push_back(x);
    end
  endtask

  task automatic wait_cyc(input int target);
    int n;
    n = 0;
    while (cyc < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("drain_timeout_pending", sb_q.size(), 0);
    sb_q.delete();
    @(negedge clk);
  endtask

  // Monitor: on each rising done, pop the expected sweep result and compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_prev = 1'b0;
    end else begin
      if (done && !done_prev) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, expected no sweep pending (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          check("latency", cyc - e.start_edge, e.lat);
          check("err_cnt", int'(err_cnt), e.err);
          check("fail_idx", int'(fail_idx), e.fidx);
          check("fail_valid", int'(fail_valid), e.fvalid);
          check("pass", int'(pass), e.pss);
          check("busy_in_done", int'(busy), 0);
          check("operands_in_done", int'({a1, a2, b1, b2}), 0);
        end
      end
      done_prev = done;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    check("rst_fail_idx", int'(fail_idx), 0);
    check("rst_fail_valid", int'(fail_valid), 0);
    check("rst_operands", int'({a1, a2, b1, b2}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Good comparator: full clean sweep, plus an in-flight operand check at vector 1.
    mode = 0;
    pulse_start(1'b1, 48, 0, 0, 0, 1);
    wait_cyc(last_start + 4);
    check("busy_mid_sweep", int'(busy), 1);
    check("operands_vec1", int'({a1, a2, b1, b2}), 4'b1000);
    wait_drain(200);

    // E stuck at 0: vectors 0,5,10,15 fail.
    mode = 1;
    if (STOP) pulse_start(1'b1, 3, 1, 0, 1, 0);
    else      pulse_start(1'b1, 48, 4, 0, 1, 0);
    wait_drain(200);

    // LB/RB swapped: every unequal vector fails, first at idx 1.
    mode = 2;
    if (STOP) pulse_start(1'b1, 6, 1, 1, 1, 0);
    else      pulse_start(1'b1, 48, 12, 1, 1, 0);
    wait_drain(200);

    // All-zero response: every vector fails, count reaches 16.
    mode = 3;
    if (STOP) pulse_start(1'b1, 3, 1, 0, 1, 0);
    else      pulse_start(1'b1, 48, 16, 0, 1, 0);
    wait_drain(200);

    // Restart from DONE clears counters; starts while busy are ignored.
    mode = 0;
    pulse_start(1'b1, 48, 0, 0, 0, 1);
    wait_cyc(last_start + 4);
    pulse_start(1'b0, 0, 0, 0, 0, 0);
    wait_cyc(last_start + 19);
    pulse_start(1'b0, 0, 0, 0, 0, 0);
    wait_drain(200);
    pulse_start(1'b1, 48, 0, 0, 0, 1);
    wait_drain(200);

    // Asynchronous reset mid-sweep, then a normal sweep.
    mode = 1;
    if (STOP) pulse_start(1'b1, 3, 1, 0, 1, 0);
    else      pulse_start(1'b1, 48, 4, 0, 1, 0);
    wait_cyc(last_start + 19);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_err_cnt", int'(err_cnt), 0);
    check("arst_fail_valid", int'(fail_valid), 0);
    check("arst_operands", int'({a1, a2, b1, b2}), 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mode = 0;
    pulse_start(1'b1, 48, 0, 0, 0, 1);
    wait_drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
